temp_bcd_conv: RTL and testbench
================================

# temp_bcd_conv

Multi-channel successor to the single-sensor temperature converter: accepts 16-bit signed fixed-point sensor words tagged with a channel number and converts each to sign plus BCD hundreds/tens/units/tenths. An iterative double-dabble engine performs the conversion. Each channel has a hot/normal/cold classifier with hysteresis. The block sits between the sensor-read sequencer and the 7-segment display multiplexer.

## Interface
- CHANNELS, 4: number of independent classifier channels (1..16).
- FRAC_BITS, 1: fraction bits used from data[7:8-FRAC_BITS] (1..4).
- HOT_TH, 16'sh1F80: hot threshold, raw signed units (31.5).
- COLD_TH, 16'sh1B80: cold threshold, raw signed units (27.5).
- HYST, 16'h0080: hysteresis, raw units (0.5).
- CW = max(1, $clog2(CHANNELS)): channel field width (derived, not overridable).

Ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  sample present.
- in_ready  out  1  engine idle; handshake when in_valid & in_ready at a rising edge.
- in_chan  in  CW  channel of sample.
- data  in  16  two's-complement: integer in [15:8], fraction in [7:0], LSB weight 2^-8.
- out_valid  out  1  one-cycle pulse: result fields valid.
- out_chan  out  CW  channel of result.
- tempsign  out  1  1 = negative.
- tempcem, tempdez, tempuni  out  4 each  BCD hundreds/tens/units of |integer part|.
- tempdec  out  4  tenths digit.
- sel  out  2  classification: 00 unknown, 01 cold, 10 normal, 11 hot.

## Operation
- FSM: IDLE -> CONV -> DONE -> IDLE. in_ready = (state == IDLE).
- IDLE, on handshake:
  - Latch chan.
  - sign = data[15].
  - mag = sign ? -data : data (16-bit; 0x8000 gives mag 0x8000 = 128.0).
  - Load 8-bit int = mag[15:8] into the shift register; clear the 12-bit BCD accumulator.
  - Run the classifier update for chan.
- CONV: exactly 8 iterations, one per cycle. Each iteration adds 3 to every BCD nibble >= 5, then shifts {bcd, int} left 1.
- DONE: drive the result registers and pulse out_valid.
  - tempdec = (f * 10) >> FRAC_BITS, truncated; f = mag[7:8-FRAC_BITS]. FRAC_BITS=1 gives 0 or 5.
  - Fraction bits below 8-FRAC_BITS are ignored.
- Classifier: per-channel 2-bit state, reset to 00. Comparisons are signed 16-bit on raw data.
  - From 00: >= HOT_TH gives 11; < COLD_TH gives 01; otherwise 10.
  - From 10: >= HOT_TH gives 11; < COLD_TH gives 01.
  - From 11: < COLD_TH gives 01; < HOT_TH-HYST gives 10; otherwise stays 11.
  - From 01: >= HOT_TH gives 11; >= COLD_TH+HYST gives 10; otherwise stays 01.
  - sel output = the updated state of the converted channel.
- in_chan >= CHANNELS: converted normally; sel = 00; no classifier state is modified.
- in_valid while not ready: ignored. No buffering, no error flag.
- Output fields hold their last values between pulses. out_valid carries no backpressure.

## Timing
- Handshake at edge E0. CONV occupies E1..E8. Result registered at E9.
- out_valid is high in the cycle after E9, and in_ready is high in that same cycle. Latency is 9 clocks.
- Next handshake is possible at E10, giving a maximum throughput of 1 sample per 10 cycles.
- Reset values: out_valid 0, in_ready 1, all data outputs 0, sel 0, every classifier state 00, FSM IDLE.
- rst asserted mid-conversion aborts immediately. No out_valid is produced for the aborted sample.
- rst deassertion is synchronised externally. The first handshake is allowed at the first edge after deassertion.

## Test plan
- After reset, chan 0, data 0x1F80 -> after 9 clocks: out_valid pulse, sign 0, digits 0/3/1/5, sel 11, out_chan 0.
- chan 2, 0xE680 (-25.5) -> sign 1, digits 0/2/5/5, sel 01. Then 0x8000 -> sign 1, digits 1/2/8/0, sel 01.
- Hysteresis on chan 1:
  - 0x1F80 -> 11.
  - 0x1F00 (31.0) -> 11.
  - 0x1E80 (30.5) -> 10.
  - 0x1B00 (27.0) -> 01.
  - 0x1B80 (27.5) -> 01.
  - 0x1C00 (28.0) -> 10.
- Channel isolation: chan 0 driven hot, then chan 3 at 0x1D00 -> chan 3 sel 10. Chan 0 re-sent at 0x1F00 -> still 11.
- Busy/reset:
  - in_valid held high with changing data -> only samples at in_ready edges are converted, one pulse per 10 cycles.
  - rst pulsed at E4 -> no out_valid; all outputs 0; next sample's sel is computed from state 00.
- FRAC_BITS=4 build, data 0x0CC0 (12.75, f=12) -> digits 0/1/2/7.

Source files
------------

// File: rtl/temp_bcd_conv.sv
// temp_bcd_conv
//   Multi-channel temperature converter. Takes a 16-bit signed fixed-point
//   sensor word (integer in [15:8], fraction in [7:0]) tagged with a channel
//   number. It produces the sign, the BCD hundreds/tens/units of the integer
//   magnitude and a tenths digit. The BCD digits come from an iterative
//   double-dabble engine that runs for 8 cycles. Each channel also keeps a
//   hot/normal/cold classification with hysteresis.
//
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   in_valid/in_ready   input handshake; in_ready is high only while idle
//   in_chan             channel tag of the incoming sample
//   data                two's-complement sample, LSB weight 2^-8
//   out_valid           one-cycle pulse when the result fields are updated
//   out_chan            channel tag of the result
//   tempsign            1 = negative sample
//   tempcem/dez/uni     BCD hundreds/tens/units of |integer part|
//   tempdec             tenths digit derived from the top FRAC_BITS fraction bits
//   sel                 classification: 00 unknown, 01 cold, 10 normal, 11 hot
module temp_bcd_conv #(
  parameter int                 CHANNELS  = 4,
  parameter int                 FRAC_BITS = 1,
  parameter logic signed [15:0] HOT_TH    = 16'sh1F80,
  parameter logic signed [15:0] COLD_TH   = 16'sh1B80,
  parameter logic        [15:0] HYST      = 16'h0080,
  localparam int                CW        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [CW-1:0] in_chan,
  input  logic [15:0]   data,
  output logic          out_valid,
  output logic [CW-1:0] out_chan,
  output logic          tempsign,
  output logic [3:0]    tempcem,
  output logic [3:0]    tempdez,
  output logic [3:0]    tempuni,
  output logic [3:0]    tempdec,
  output logic [1:0]    sel
);

  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

  localparam logic [1:0] CLS_UNK  = 2'b00;
  localparam logic [1:0] CLS_COLD = 2'b01;
  localparam logic [1:0] CLS_NORM = 2'b10;
  localparam logic [1:0] CLS_HOT  = 2'b11;

  // Hysteresis band edges used when leaving the hot or cold state.
  localparam logic signed [15:0] HOT_LO  = HOT_TH - $signed(HYST);
  localparam logic signed [15:0] COLD_HI = COLD_TH + $signed(HYST);

  state_t        state_q, state_d;
  logic [2:0]    iter_q, iter_d;
  logic [7:0]    int_q, int_d;
  logic [11:0]   bcd_q, bcd_d;
  logic          sign_q, sign_d;
  logic [3:0]    frac_q, frac_d;
  logic [CW-1:0] chan_q, chan_d;
  logic [1:0]    cls_res_q, cls_res_d;
  logic [1:0]    cls_q [CHANNELS];
  logic [1:0]    cls_d [CHANNELS];

  logic          out_valid_q, out_valid_d;
  logic [CW-1:0] out_chan_q, out_chan_d;
  logic          tempsign_q, tempsign_d;
  logic [3:0]    tempcem_q, tempcem_d;
  logic [3:0]    tempdez_q, tempdez_d;
  logic [3:0]    tempuni_q, tempuni_d;
  logic [3:0]    tempdec_q, tempdec_d;
  logic [1:0]    sel_q, sel_d;

  logic          hs;
  logic          chan_ok;
  logic [15:0]   mag;
  logic [11:0]   bcd_adj;

  // Next classification for one channel given its current state and the raw sample.
  function automatic logic [1:0] classify(input logic [1:0] cur, input logic signed [15:0] v);
    logic [1:0] nxt;
    nxt = cur;
    case (cur)
      CLS_HOT: begin
        if (v < COLD_TH)     nxt = CLS_COLD;
        else if (v < HOT_LO) nxt = CLS_NORM;
        else                 nxt = CLS_HOT;
      end
      CLS_COLD: begin
        if (v >= HOT_TH)       nxt = CLS_HOT;
        else if (v >= COLD_HI) nxt = CLS_NORM;
        else                   nxt = CLS_COLD;
      end
      default: begin
        if (v >= HOT_TH)       nxt = CLS_HOT;
        else if (v < COLD_TH)  nxt = CLS_COLD;
        else                   nxt = CLS_NORM;
      end
    endcase
    return nxt;
  endfunction

  // 0x8000 negates to itself, which reads correctly as magnitude 128.0.
  always_comb begin
    hs      = in_valid && (state_q == IDLE);
    chan_ok = (32'(in_chan) < CHANNELS);
    mag     = data[15] ? (16'd0 - data) : data;
  end

  always_comb begin
    state_d     = state_q;
    iter_d      = iter_q;
    int_d       = int_q;
    bcd_d       = bcd_q;
    sign_d      = sign_q;
    frac_d      = frac_q;
    chan_d      = chan_q;
    cls_res_d   = cls_res_q;
    cls_d       = cls_q;
    out_valid_d = 1'b0;
    out_chan_d  = out_chan_q;
    tempsign_d  = tempsign_q;
    tempcem_d   = tempcem_q;
    tempdez_d   = tempdez_q;
    tempuni_d   = tempuni_q;
    tempdec_d   = tempdec_q;
    sel_d       = sel_q;
    bcd_adj     = bcd_q;

    case (state_q)
      IDLE: begin
        if (hs) begin
          state_d   = CONV;
          iter_d    = 3'd0;
          sign_d    = data[15];
          int_d     = mag[15:8];
          bcd_d     = 12'd0;
          frac_d    = 4'(mag[7:0] >> (8 - FRAC_BITS));
          chan_d    = in_chan;
          // Out-of-range channels are converted but never touch classifier state.
          cls_res_d = CLS_UNK;
          if (chan_ok) begin
            cls_res_d      = classify(cls_q[in_chan], $signed(data));
            cls_d[in_chan] = cls_res_d;
          end
        end
      end
      CONV: begin
        // One double-dabble step: correct every nibble >= 5, then shift.
        for (int n = 0; n < 3; n++) begin
          if (bcd_adj[n*4 +: 4] >= 4'd5) begin
            bcd_adj[n*4 +: 4] = bcd_adj[n*4 +: 4] + 4'd3;
          end
        end
        {bcd_d, int_d} = {bcd_adj, int_q} << 1;
        iter_d = iter_q + 3'd1;
        if (iter_q == 3'd7) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d     = IDLE;
        out_valid_d = 1'b1;
        out_chan_d  = chan_q;
        tempsign_d  = sign_q;
        tempcem_d   = bcd_q[11:8];
        tempdez_d   = bcd_q[7:4];
        tempuni_d   = bcd_q[3:0];
        tempdec_d   = 4'(({4'd0, frac_q} * 8'd10) >> FRAC_BITS);
        sel_d       = cls_res_q;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      iter_q      <= 3'd0;
      int_q       <= 8'd0;
      bcd_q       <= 12'd0;
      sign_q      <= 1'b0;
      frac_q      <= 4'd0;
      chan_q      <= '0;
      cls_res_q   <= CLS_UNK;
      for (int i = 0; i < CHANNELS; i++) begin
        cls_q[i] <= CLS_UNK;
      end
      out_valid_q <= 1'b0;
      out_chan_q  <= '0;
      tempsign_q  <= 1'b0;
      tempcem_q   <= 4'd0;
      tempdez_q   <= 4'd0;
      tempuni_q   <= 4'd0;
      tempdec_q   <= 4'd0;
      sel_q       <= 2'b00;
    end else begin
      state_q     <= state_d;
      iter_q      <= iter_d;
      int_q       <= int_d;
      bcd_q       <= bcd_d;
      sign_q      <= sign_d;
      frac_q      <= frac_d;
      chan_q      <= chan_d;
      cls_res_q   <= cls_res_d;
      cls_q       <= cls_d;
      out_valid_q <= out_valid_d;
      out_chan_q  <= out_chan_d;
      tempsign_q  <= tempsign_d;
      tempcem_q   <= tempcem_d;
      tempdez_q   <= tempdez_d;
      tempuni_q   <= tempuni_d;
      tempdec_q   <= tempdec_d;
      sel_q       <= sel_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = out_valid_q;
  assign out_chan  = out_chan_q;
  assign tempsign  = tempsign_q;
  assign tempcem   = tempcem_q;
  assign tempdez   = tempdez_q;
  assign tempuni   = tempuni_q;
  assign tempdec   = tempdec_q;
  assign sel       = sel_q;

endmodule

// File: tb/tb_temp_bcd_conv.sv
// tb_temp_bcd_conv
//   Directed bench for temp_bcd_conv. Expected results are pushed into a
//   scoreboard queue together with the cycle in which they must appear; a
//   monitor pops and compares on every out_valid pulse. A second instance
//   built with FRAC_BITS=4 covers the wider tenths computation.
module tb_temp_bcd_conv;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_chan;
  logic [15:0] data;
  logic        out_valid;
  logic [1:0]  out_chan;
  logic        tempsign;
  logic [3:0]  tempcem, tempdez, tempuni, tempdec;
  logic [1:0]  sel;

  logic        in_valid4;
  logic        in_ready4;
  logic [1:0]  in_chan4;
  logic [15:0] data4;
  logic        out_valid4;
  logic [1:0]  out_chan4;
  logic        tempsign4;
  logic [3:0]  tempcem4, tempdez4, tempuni4, tempdec4;
  logic [1:0]  sel4;

  typedef struct {
    int         cyc;
    logic [1:0] chan;
    logic       sign;
    logic [3:0] cem;
    logic [3:0] dez;
    logic [3:0] uni;
    logic [3:0] dec;
    logic [1:0] sel;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;

  temp_bcd_conv u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_chan(in_chan), .data(data), .out_valid(out_valid), .out_chan(out_chan),
    .tempsign(tempsign), .tempcem(tempcem), .tempdez(tempdez), .tempuni(tempuni),
    .tempdec(tempdec), .sel(sel)
  );

  temp_bcd_conv #(.FRAC_BITS(4)) u_dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4),
    .in_chan(in_chan4), .data(data4), .out_valid(out_valid4), .out_chan(out_chan4),
    .tempsign(tempsign4), .tempcem(tempcem4), .tempdez(tempdez4), .tempuni(tempuni4),
    .tempdec(tempdec4), .sel(sel4)
  );

  always #5 clk = ~clk;

  // Counts rising edges; read at falling edges where it is stable.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Drives one sample into an idle DUT and leaves it idle again 10 cycles later.
  task automatic applyStimulus(input logic [1:0] ch, input logic [15:0] d, input logic s,
                               input logic [3:0] cem, input logic [3:0] dez,
                               input logic [3:0] uni, input logic [3:0] dec,
                               input logic [1:0] sl);
    @(negedge clk);
    checkOutput("in_ready idle", 16'(in_ready), 16'd1);
    in_valid = 1'b1;
    in_chan  = ch;
    data     = d;
    sb.push_back('{cyc + 10, ch, s, cem, dez, uni, dec, sl});
    @(negedge clk);
    in_valid = 1'b0;
    data     = 16'h0000;
    repeat (8) @(negedge clk);
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst && out_valid) begin
      if (sb.size() == 0) begin
        checkOutput("unexpected out_valid", 16'd1, 16'd0);
      end else begin
        e = sb.pop_front();
        checkOutput("latency cycle", 16'(cyc), 16'(e.cyc));
        checkOutput("out_chan", 16'(out_chan), 16'(e.chan));
        checkOutput("tempsign", 16'(tempsign), 16'(e.sign));
        checkOutput("tempcem", 16'(tempcem), 16'(e.cem));
        checkOutput("tempdez", 16'(tempdez), 16'(e.dez));
        checkOutput("tempuni", 16'(tempuni), 16'(e.uni));
        checkOutput("tempdec", 16'(tempdec), 16'(e.dec));
        checkOutput("sel", 16'(sel), 16'(e.sel));
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stim
    logic got4;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_chan   = 2'd0;
    data      = 16'h0000;
    in_valid4 = 1'b0;
    in_chan4  = 2'd0;
    data4     = 16'h0000;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    checkOutput("reset out_valid", 16'(out_valid), 16'd0);
    checkOutput("reset in_ready", 16'(in_ready), 16'd1);
    checkOutput("reset out_chan", 16'(out_chan), 16'd0);
    checkOutput("reset tempsign", 16'(tempsign), 16'd0);
    checkOutput("reset digits", {tempcem, tempdez, tempuni, tempdec}, 16'h0000);
    checkOutput("reset sel", 16'(sel), 16'd0);

    // Basic conversions.
    applyStimulus(2'd0, 16'h1F80, 1'b0, 4'd0, 4'd3, 4'd1, 4'd5, 2'b11);
    applyStimulus(2'd2, 16'hE680, 1'b1, 4'd0, 4'd2, 4'd5, 4'd5, 2'b01);
    applyStimulus(2'd2, 16'h8000, 1'b1, 4'd1, 4'd2, 4'd8, 4'd0, 2'b01);

    // Hysteresis walk on channel 1.
    applyStimulus(2'd1, 16'h1F80, 1'b0, 4'd0, 4'd3, 4'd1, 4'd5, 2'b11);
    applyStimulus(2'd1, 16'h1F00, 1'b0, 4'd0, 4'd3, 4'd1, 4'd0, 2'b11);
    applyStimulus(2'd1, 16'h1E80, 1'b0, 4'd0, 4'd3, 4'd0, 4'd5, 2'b10);
    applyStimulus(2'd1, 16'h1B00, 1'b0, 4'd0, 4'd2, 4'd7, 4'd0, 2'b01);
    applyStimulus(2'd1, 16'h1B80, 1'b0, 4'd0, 4'd2, 4'd7, 4'd5, 2'b01);
    applyStimulus(2'd1, 16'h1C00, 1'b0, 4'd0, 4'd2, 4'd8, 4'd0, 2'b10);

    // Channel isolation.
    applyStimulus(2'd3, 16'h1D00, 1'b0, 4'd0, 4'd2, 4'd9, 4'd0, 2'b10);
    applyStimulus(2'd0, 16'h1F00, 1'b0, 4'd0, 4'd3, 4'd1, 4'd0, 2'b11);

    // in_valid held high: only edges where the DUT is idle accept a sample.
    @(negedge clk);
    for (int k = 0; k < 30; k++) begin
      checkOutput("in_ready busy", 16'(in_ready), (k % 10 == 0) ? 16'd1 : 16'd0);
      in_valid = 1'b1;
      in_chan  = 2'd2;
      case (k)
        0: begin
          data = 16'h0500;
          sb.push_back('{cyc + 10, 2'd2, 1'b0, 4'd0, 4'd0, 4'd5, 4'd0, 2'b01});
        end
        10: begin
          data = 16'h6400;
          sb.push_back('{cyc + 10, 2'd2, 1'b0, 4'd1, 4'd0, 4'd0, 4'd0, 2'b11});
        end
        20: begin
          data = 16'hFF80;
          sb.push_back('{cyc + 10, 2'd2, 1'b1, 4'd0, 4'd0, 4'd0, 4'd5, 2'b01});
        end
        default: data = 16'h7F00 ^ 16'(k);
      endcase
      @(negedge clk);
    end
    in_valid = 1'b0;
    data     = 16'h0000;
    repeat (2) @(negedge clk);

    // Reset in the middle of a conversion: no result, outputs cleared.
    in_valid = 1'b1;
    in_chan  = 2'd1;
    data     = 16'h1F80;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("abort in_ready", 16'(in_ready), 16'd1);
    checkOutput("abort out_valid", 16'(out_valid), 16'd0);
    checkOutput("abort tempsign", 16'(tempsign), 16'd0);
    checkOutput("abort digits", {tempcem, tempdez, tempuni, tempdec}, 16'h0000);
    checkOutput("abort sel", 16'(sel), 16'd0);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    checkOutput("post-abort digits", {tempcem, tempdez, tempuni, tempdec}, 16'h0000);
    // Channel 0 was hot; from a cleared state 31.25 classifies as normal.
    applyStimulus(2'd0, 16'h1F40, 1'b0, 4'd0, 4'd3, 4'd1, 4'd0, 2'b10);

    // FRAC_BITS=4 instance: 12.75 -> tenths 7.
    @(negedge clk);
    in_valid4 = 1'b1;
    in_chan4  = 2'd0;
    data4     = 16'h0CC0;
    @(negedge clk);
    in_valid4 = 1'b0;
    got4 = 1'b0;
    for (int w = 0; w < 20 && !got4; w++) begin
      @(negedge clk);
      if (out_valid4) got4 = 1'b1;
    end
    if (!got4) begin
      checkOutput("frac4 out_valid timeout", 16'd0, 16'd1);
    end else begin
      checkOutput("frac4 digits", {tempcem4, tempdez4, tempuni4, tempdec4}, 16'h0127);
      checkOutput("frac4 sign", 16'(tempsign4), 16'd0);
      checkOutput("frac4 sel", 16'(sel4), 16'd1);
    end

    for (int w = 0; w < 20 && sb.size() > 0; w++) @(negedge clk);
    while (sb.size() > 0) begin
      sb.delete(0);
      checkOutput("missing out_valid", 16'd0, 16'd1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
